fft_stage_sched: RTL
====================

// Module: fft_stage_sched
// PURPOSE
//   Sequencer for the shared 4-MAC, 32-point butterfly array (fftc3 class datapath).
//   - Accepts one 32-point complex frame over a valid/ready handshake.
//   - Drives the 2-bit phase select to time-multiplex the MACs over NUM_STAGES passes.
//   - Captures the phase-qualified lanes of the array output into a result buffer.
//   - Presents the finished frame downstream over valid/ready.
// PARAMETERS
//   NPTS        32  complex points per frame; each point is 64 bits ({re[63:32], im[31:0]}, fp32)
//   NUM_STAGES  1   passes through the array per frame (1..8); result of pass s is operand of pass s+1
//   MAC_LAT     0   register latency of array from mac_sel/mac_in to mac_out (0..4 cycles)
// PORTS
//   clk        in   1          single clock, rising edge
//   reset_n    in   1          asynchronous, active-low reset
//   in_valid   in   1          upstream frame valid
//   in_ready   out  1          scheduler can accept a frame
//   in_data    in   64*NPTS    frame; point k at [64k+63:64k]
//   mac_in     out  64*NPTS    operand buffer driven to array input
//   mac_sel    out  2          phase select to array (lanes k with k%4==mac_sel are produced)
//   mac_stage  out  3          current pass index, for twiddle selection
//   mac_issue  out  1          high while mac_sel carries a live phase
//   mac_out    in   64*NPTS    array output bus
//   out_valid  out  1          result frame valid
//   out_ready  in   1          downstream accepts result
//   out_data   out  64*NPTS    result buffer
//   busy       out  1          high in any state except IDLE
// BEHAVIOUR
//   Reset (async, reset_n=0)
//     - state=IDLE; all buffers, mac_sel, mac_stage and the phase/stage counters are 0.
//     - in_ready=1, out_valid=0, mac_issue=0, busy=0.
//     - Reset asserted mid-frame discards the frame. No output is produced for it.
//   FSM states: IDLE, RUN, XFER, DONE
//   IDLE
//     - in_ready=1.
//     - in_valid&in_ready: latch in_data into the operand buffer; stage=0, phase=0; go to RUN.
//   RUN (4+MAC_LAT cycles per pass)
//     - Issue cycles i=0..3: mac_sel=i, mac_issue=1.
//     - Cycles 4..3+MAC_LAT: mac_issue=0, mac_sel holds 3.
//     - Capture for phase p happens at RUN cycle p+MAC_LAT. Lanes k with k%4==p load mac_out[k] into the result buffer.
//     - All other lanes hold their value.
//     - After the last capture: go to XFER if stage<NUM_STAGES-1, otherwise go to DONE.
//   XFER (1 cycle)
//     - Result buffer is copied into the operand buffer. stage increments; phase=0; go to RUN.
//   DONE
//     - out_valid=1. out_data is stable until accepted.
//     - out_valid&out_ready: go to IDLE next cycle.
//     - out_ready=0 stalls indefinitely with no data change.
//   Handshakes
//     - in_ready is 0 outside IDLE.
//     - in_valid arriving in the same cycle as the DONE handshake is ignored. It is accepted the following cycle in IDLE.
//   Latency (accept edge = cycle 0)
//     - out_valid rises at cycle 1 + NUM_STAGES*(4+MAC_LAT) + (NUM_STAGES-1).
//     - Example: NUM_STAGES=1, MAC_LAT=0 gives cycle 5.
//   Counters
//     - phase is a 2-bit counter and wraps 3->0 only at a pass boundary.
//     - stage saturates at NUM_STAGES-1.
//   Data arithmetic: none. Data is moved, never modified.
// CONFIGURATION
//   FFT_SCHED_PERF_EN defined:
//     - Adds output frame_cnt[15:0]. It increments on each DONE handshake and wraps 0xFFFF->0.
//     - Adds output stall_cnt[15:0]. It increments each DONE cycle with out_ready=0 and saturates at 0xFFFF.
//     - Both are 0 on reset.
//   FFT_SCHED_PERF_EN undefined: the ports and counters are absent, and behaviour is otherwise identical.
// TESTING
//   1. Reset:
//      - Drive reset_n=0 with in_valid=1 -> in_ready=1, out_valid=0, mac_issue=0, mac_sel=0, out_data=0.
//   2. Single pass, NUM_STAGES=1, MAC_LAT=0:
//      - Stimulus: frame point k=k, identity array model (mac_out=mac_in).
//      - Required: mac_sel sequence 0,1,2,3 on cycles 1-4; out_valid at cycle 5; out_data==in_data.
//   3. Lane qualification:
//      - Stimulus: array model drives mac_out[k]=0xA5A5_0000_0000_0000|(mac_sel<<8)|k.
//      - Required: result lane k == ...|((k%4)<<8)|k.
//   4. Multi-pass, NUM_STAGES=3, MAC_LAT=2:
//      - Stimulus: array model adds 1 to each lane per pass.
//      - Required: mac_stage steps 0,1,2; out_valid at cycle 21; lane k == k+3.
//   5. Backpressure:
//      - Stimulus: hold out_ready=0 for 10 cycles in DONE, with in_valid=1 throughout.
//      - Required: out_data stable, in_ready=0; the next frame is accepted exactly 1 cycle after the handshake.
//   6. Abort:
//      - Stimulus: pulse reset_n=0 at RUN cycle 2.
//      - Required: immediate IDLE, busy=0, no out_valid; the next frame completes normally.
//      - With FFT_SCHED_PERF_EN: frame_cnt==1 after that frame.

Source files
------------

// File: rtl/fft_stage_sched.sv
// fft_stage_sched: sequencer for the shared 4-MAC, 32-point butterfly array.
// Defining FFT_SCHED_PERF_EN adds the frame_cnt/stall_cnt performance counter outputs.
module fft_stage_sched #(
  parameter int NPTS       = 32,
  parameter int NUM_STAGES = 1,
  parameter int MAC_LAT    = 0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [64*NPTS-1:0]   in_data,
  output logic [64*NPTS-1:0]   mac_in,
  output logic [1:0]           mac_sel,
  output logic [2:0]           mac_stage,
  output logic                 mac_issue,
  input  logic [64*NPTS-1:0]   mac_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [64*NPTS-1:0]   out_data,
  output logic                 busy
`ifdef FFT_SCHED_PERF_EN
  ,
  output logic [15:0]          frame_cnt,
  output logic [15:0]          stall_cnt
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_XFER = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [2:0] LAST_CYC   = 3'(4 + MAC_LAT - 1);
  localparam logic [2:0] LAST_STAGE = 3'(NUM_STAGES - 1);
  localparam logic [3:0] LAT4       = 4'(MAC_LAT);

  logic [1:0]          state;
  logic [2:0]          run_cyc;
  logic [1:0]          phase;
  logic [2:0]          stage;
  logic [64*NPTS-1:0]  op_buf;
  logic [64*NPTS-1:0]  res_buf;
  logic [3:0]          cap_idx;
  logic                cap_en;
  logic [1:0]          cap_phase;

  // The array output for phase p arrives MAC_LAT cycles after it was issued;
  // a borrow in cap_idx means that cycle is still inside the latency window.
  assign cap_idx   = {1'b0, run_cyc} - LAT4;
  assign cap_en    = (state == S_RUN) && (cap_idx[3:2] == 2'b00);
  assign cap_phase = cap_idx[1:0];

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);
  assign mac_issue = (state == S_RUN) && (run_cyc < 3'd4);
  assign mac_sel   = phase;
  assign mac_stage = stage;
  assign mac_in    = op_buf;
  assign out_data  = res_buf;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      run_cyc <= 3'd0;
      phase   <= 2'd0;
      stage   <= 3'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            state   <= S_RUN;
            run_cyc <= 3'd0;
            phase   <= 2'd0;
            stage   <= 3'd0;
          end
        end
        S_RUN: begin
          // phase parks on 3 through the latency tail; it only returns to 0 at a pass boundary
          if (run_cyc < 3'd3) begin
            phase <= phase + 2'd1;
          end
          if (run_cyc == LAST_CYC) begin
            run_cyc <= 3'd0;
            state   <= (stage == LAST_STAGE) ? S_DONE : S_XFER;
          end else begin
            run_cyc <= run_cyc + 3'd1;
          end
        end
        S_XFER: begin
          state   <= S_RUN;
          run_cyc <= 3'd0;
          phase   <= 2'd0;
          if (stage != LAST_STAGE) begin
            stage <= stage + 3'd1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_buf  <= '0;
      res_buf <= '0;
    end else begin
      if (state == S_IDLE && in_valid) begin
        op_buf <= in_data;
      end else if (state == S_XFER) begin
        op_buf <= res_buf;
      end
      if (cap_en) begin
        for (int k = 0; k < NPTS; k++) begin
          if (2'(k) == cap_phase) begin
            res_buf[64*k +: 64] <= mac_out[64*k +: 64];
          end
        end
      end
    end
  end

`ifdef FFT_SCHED_PERF_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt <= 16'd0;
      stall_cnt <= 16'd0;
    end else if (state == S_DONE) begin
      if (out_ready) begin
        frame_cnt <= frame_cnt + 16'd1;
      end else if (stall_cnt != 16'hFFFF) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
    end
  end
`else
  // Performance counters are not built in this configuration.
`endif

endmodule
